// File: rtl/noise_icdf_pipe_if.sv
// Bus bundle for the inverse-CDF noise pipe: table load port, uniform sample
// input handshake and the noise output stream.
interface noise_icdf_pipe_if #(
  parameter int CDF_W  = 64,
  parameter int LOG2_N = 7,
  parameter int OUT_W  = 8
);
  logic                     en;
  logic                     clear;
  logic                     load_mem;
  logic [LOG2_N-1:0]        location;
  logic [CDF_W-1:0]         mem_data;
  logic                     table_ready;
  logic [CDF_W-1:0]         urng_data;
  logic                     urng_valid;
  logic                     urng_ready;
  logic signed [OUT_W-1:0]  noise_out;
  logic                     noise_out_valid;
  logic [31:0]              sample_count;

  modport master (
    output en, clear, load_mem, location, mem_data, urng_data, urng_valid,
    input  table_ready, urng_ready, noise_out, noise_out_valid, sample_count
  );

  modport slave (
    input  en, clear, load_mem, location, mem_data, urng_data, urng_valid,
    output table_ready, urng_ready, noise_out, noise_out_valid, sample_count
  );
endinterface

// File: rtl/noise_icdf_pipe.sv
// Discrete-Gaussian style noise sampler: a uniform sample is mapped through a
// CDF threshold table with a pipelined binary search, one result bit per stage.

// One search step: probe the midpoint above the current prefix and keep the
// bit when the sample is at or above that threshold.
module noise_icdf_stage #(
  parameter int CDF_W  = 64,
  parameter int LOG2_N = 7,
  parameter int BIT    = 0
) (
  input  logic [CDF_W-1:0]  u_i,
  input  logic [LOG2_N-1:0] pfx_i,
  input  logic [CDF_W-1:0]  thr_i,
  output logic [LOG2_N-1:0] addr_o,
  output logic [LOG2_N-1:0] pfx_o
);
  logic [LOG2_N-1:0] probe;

  assign probe  = pfx_i | (LOG2_N'(1) << BIT);
  assign addr_o = probe - LOG2_N'(1);
  assign pfx_o  = (u_i >= thr_i) ? probe : pfx_i;
endmodule

module noise_icdf_pipe #(
  parameter int CDF_W  = 64,
  parameter int LOG2_N = 7,
  parameter int OUT_W  = 8,
  parameter int OFFSET = 63
) (
  input  logic            clk,
  input  logic            rstn,
  noise_icdf_pipe_if.slave bus
);
  localparam int N = 1 << LOG2_N;
  localparam int S = LOG2_N;

  logic [CDF_W-1:0]              tbl_q [N];
  logic [N-1:0]                  wr_q, wr_d;
  logic                          rdy_q;
  logic [S-1:0][CDF_W-1:0]       stg_u_q;
  logic [S-1:0][LOG2_N-1:0]      stg_pfx_q;
  logic [S:0]                    vld_pipe;
  logic signed [OUT_W-1:0]       noise_q;
  logic [31:0]                   cnt_q;

  logic [S-1:0][LOG2_N-1:0]      addr;
  logic [S-1:0][LOG2_N-1:0]      nxt_pfx;
  logic [S-1:0][CDF_W-1:0]       thr;
  logic signed [OUT_W-1:0]       noise_d;
  logic                          accept;
  logic                          flush;

  assign bus.urng_ready      = bus.en & rdy_q & ~bus.load_mem & ~bus.clear;
  assign accept              = bus.urng_ready & bus.urng_valid;
  // Any table write kills in-flight work so no result mixes old and new entries.
  assign flush               = bus.clear | bus.load_mem;
  assign bus.table_ready     = rdy_q;
  assign bus.noise_out       = noise_q;
  assign bus.noise_out_valid = vld_pipe[S];
  assign bus.sample_count    = cnt_q;

  for (genvar s = 0; s < S; s++) begin : g_stg
    noise_icdf_stage #(.CDF_W(CDF_W), .LOG2_N(LOG2_N), .BIT(LOG2_N-1-s)) u_stg (
      .u_i   (stg_u_q[s]),
      .pfx_i (stg_pfx_q[s]),
      .thr_i (thr[s]),
      .addr_o(addr[s]),
      .pfx_o (nxt_pfx[s])
    );
    assign thr[s] = tbl_q[addr[s]];
  end

  assign noise_d = OUT_W'(nxt_pfx[S-1]) - OUT_W'(OFFSET);

  always_comb begin
    wr_d = wr_q;
    if (bus.clear)         wr_d = '0;
    else if (bus.load_mem) wr_d[bus.location] = 1'b1;
  end

  // Table storage carries no reset; the written-flags gate its use.
  always_ff @(posedge clk) begin
    if (bus.load_mem & ~bus.clear) tbl_q[bus.location] <= bus.mem_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q      <= '0;
      rdy_q     <= 1'b0;
      stg_u_q   <= '0;
      stg_pfx_q <= '0;
      vld_pipe  <= '0;
      noise_q   <= '0;
      cnt_q     <= '0;
    end else begin
      wr_q  <= wr_d;
      rdy_q <= &wr_d;
      cnt_q <= cnt_q + 32'(vld_pipe[S]);
      if (flush) begin
        vld_pipe <= '0;
      end else if (bus.en) begin
        vld_pipe <= {vld_pipe[S-1:0], accept};
        if (vld_pipe[S-1]) noise_q <= noise_d;
      end else begin
        vld_pipe[S] <= 1'b0;
      end
      if (bus.en) begin
        stg_u_q[0]   <= bus.urng_data;
        stg_pfx_q[0] <= '0;
        for (int s = 1; s < S; s++) begin
          stg_u_q[s]   <= stg_u_q[s-1];
          stg_pfx_q[s] <= nxt_pfx[s-1];
        end
      end
    end
  end
endmodule

// File: doc/noise_icdf_pipe.md
NOISE_ICDF_PIPE -- requirements
Module: noise_icdf_pipe

Interface
REQ-001 SHALL have parameter CDF_W, default 64, meaning width of uniform sample and CDF thresholds.
REQ-002 SHALL have parameter LOG2_N, default 7, meaning log2 of table depth N = 2^LOG2_N.
REQ-003 SHALL have parameter OUT_W, default 8, meaning signed noise width; legal only if OUT_W >= LOG2_N+1.
REQ-004 SHALL have parameter OFFSET, default 63, meaning noise value = index - OFFSET.
REQ-005 SHALL have port clk, input, 1, meaning clock.
REQ-006 SHALL have port rstn, input, 1, meaning reset, asynchronous, active-low.
REQ-007 SHALL have port en, input, 1, meaning pipeline advance enable.
REQ-008 SHALL have port clear, input, 1, meaning invalidate table and flush pipeline.
REQ-009 SHALL have port load_mem, input, 1, meaning table write strobe.
REQ-010 SHALL have port location, input, LOG2_N, meaning table write address.
REQ-011 SHALL have port mem_data, input, CDF_W, meaning CDF threshold written to location.
REQ-012 SHALL have port table_ready, output, 1, meaning all N entries written since reset/clear.
REQ-013 SHALL have port urng_data, input, CDF_W, meaning uniform sample u.
REQ-014 SHALL have port urng_valid, input, 1, meaning u is valid.
REQ-015 SHALL have port urng_ready, output, 1, meaning sample accepted this cycle if urng_valid.
REQ-016 SHALL have port noise_out, output, OUT_W signed, meaning noise sample.
REQ-017 SHALL have port noise_out_valid, output, 1, meaning one-cycle qualifier of noise_out.
REQ-018 SHALL have port sample_count, output, 32, meaning number of noise_out_valid pulses, wrapping.

Function
REQ-019 SHALL hold table T[0..N-1] plus one written-flag per entry; load_mem=1 writes T[location]=mem_data and sets its flag that cycle.
REQ-020 SHALL assert table_ready the cycle after the last unwritten flag is set; repeated writes to one entry SHALL count once.
REQ-021 SHALL drive urng_ready = en & table_ready & ~load_mem & ~clear (combinational).
REQ-022 SHALL compute index k = number of entries among T[0..N-2] with u >= T[j] (T assumed non-decreasing); k saturates at N-1.
REQ-023 SHALL resolve k by a LOG2_N-stage binary search: stage s decides bit LOG2_N-1-s; probe p = prefix | (1<<bit); bit=1 iff u >= T[p-1].
REQ-024 SHALL carry u, partial prefix and a valid bit per stage; throughput one sample per cycle.
REQ-025 SHALL register noise_out = k - OFFSET (sign-extended to OUT_W) after the last stage; latency accept-to-noise_out_valid = LOG2_N+1 cycles.
REQ-026 SHALL advance all stage registers only when en=1; en=0 freezes contents, forces noise_out_valid=0, holds noise_out; no sample lost or duplicated on resume.
REQ-027 SHALL, on load_mem=1 while table_ready=1, perform the write and clear every in-flight valid bit; no output originates from a sample in flight that cycle.
REQ-028 SHALL, on clear=1, clear all written-flags, table_ready, stage valids and noise_out_valid next cycle; clear has priority over simultaneous load_mem (write dropped).
REQ-029 SHALL increment sample_count on every cycle noise_out_valid=1, wrapping 2^32-1 -> 0.
REQ-030 SHALL never read a table entry combinationally from the write port in the same cycle it is written (write-then-read next cycle semantics).

Reset
REQ-031 SHALL on rstn=0 asynchronously clear noise_out=0, noise_out_valid=0, table_ready=0, sample_count=0, all written-flags and stage valids; T contents undefined after reset.
REQ-032 SHALL produce no noise_out_valid until table reloaded fully and a new sample accepted after rstn release.

Verification
REQ-033 Load T[k]=(k+1)<<57 for k=0..127, send u=0 -> noise_out=-63, valid exactly 8 cycles after acceptance.
REQ-034 Same table, u=2^64-1 -> noise_out=+64; u=64<<57 (equals T[63]) -> noise_out=+1.
REQ-035 Write only 127 distinct entries (location 5 twice) -> table_ready=0, urng_ready=0; write last entry -> table_ready=1 next cycle.
REQ-036 Stream 10 back-to-back samples with en toggled low 3 cycles mid-stream -> exactly 10 valid pulses, order preserved, sample_count=10.
REQ-037 Load_mem pulse with 4 samples in flight -> those 4 produce no output; next accepted sample uses new value; clear mid-stream -> table_ready=0 next cycle, no further valids.
REQ-038 Assert rstn=0 mid-stream -> all outputs 0 immediately; sample_count=0.
